// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: operand/instruction widths, program entry layout,
// the idle NOP word and the sequencer FSM states.
package alu_pkg;

    localparam int unsigned IW = 16;
    localparam int unsigned DW = 8;

    // Entry layout, MSB first: {last, skip_z, instruction, data0, data1}.
    function automatic int unsigned entry_w(input int unsigned iw, input int unsigned dw);
        return iw + 2 * dw + 2;
    endfunction

    function automatic int unsigned last_off(input int unsigned iw, input int unsigned dw);
        return iw + 2 * dw + 1;
    endfunction

    function automatic int unsigned skip_z_off(input int unsigned iw, input int unsigned dw);
        return iw + 2 * dw;
    endfunction

    localparam logic [IW+2*DW-1:0] NOP = '0;

    typedef enum logic {
        StIdle,
        StIssue
    } state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the issue sequencer: unreset register array with a synchronous
// write port and a combinational read port.
module seq_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned EW    = 34,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);

    logic [EW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issues a loaded program of ALU operations one per cycle, with zero-flag skip,
// overflow abort and downstream hold; drives the all-zero NOP word when idle.
module alu_issue_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = alu_pkg::DW,
    parameter int unsigned IW    = alu_pkg::IW,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IW+2*DW+1:0] prog_data,
    input  logic              start,
    input  logic              hold,
    input  logic              zero_flag,
    input  logic              overflow,
    output logic [IW-1:0]     instruction,
    output logic [DW-1:0]     data0,
    output logic [DW-1:0]     data1,
    output logic              issue_valid,
    output logic              busy,
    output logic              done,
    output logic              ovf_err,
    output logic [AW-1:0]     pc
);
    import alu_pkg::*;

    localparam int unsigned EW       = entry_w(IW, DW);
    localparam int unsigned WW       = IW + 2 * DW;
    localparam int unsigned LastOff  = last_off(IW, DW);
    localparam int unsigned SkipZOff = skip_z_off(IW, DW);
    localparam logic [AW:0] PcLast   = (AW+1)'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   pc_q, pc_d, pc_skip;
    logic          ovf_err_q, ovf_err_d;
    logic          done_q, done_d;
    logic          mem_we;
    logic          do_skip;
    logic [EW-1:0] entry;
    logic [WW-1:0] word;

    assign mem_we = prog_we && (state_q == StIdle);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q[AW-1:0]),
        .rdata_o (entry)
    );

    // pc carries one spare bit so pc+2 past the end is seen rather than wrapped.
    assign pc_skip = pc_q + (AW+1)'(2);
    assign do_skip = entry[SkipZOff] && zero_flag;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ovf_err_d = ovf_err_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StIssue;
                    pc_d      = '0;
                    ovf_err_d = 1'b0;
                end
            end
            StIssue: begin
                if (!hold) begin
                    if (overflow) begin
                        ovf_err_d = 1'b1;
                        state_d   = StIdle;
                        pc_d      = '0;
                    end else if (entry[LastOff] || (pc_q == PcLast)
                                 || (do_skip && (pc_skip > PcLast))) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                        pc_d    = '0;
                    end else if (do_skip) begin
                        pc_d = pc_skip;
                    end else begin
                        pc_d = pc_q + (AW+1)'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ovf_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ovf_err_q <= ovf_err_d;
            done_q    <= done_d;
        end
    end

    assign issue_valid = (state_q == StIssue);
    assign busy        = issue_valid;
    assign word        = issue_valid ? entry[WW-1:0] : WW'(NOP);
    assign instruction = word[WW-1 -: IW];
    assign data0       = word[2*DW-1 -: DW];
    assign data1       = word[DW-1:0];
    assign done        = done_q;
    assign ovf_err     = ovf_err_q;
    assign pc          = pc_q[AW-1:0];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: directed scenarios plus random programs,
// checked against a program-level expected issue trace.
module tb_alu_issue_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned EW    = IW + 2 * DW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [EW-1:0] prog_data = '0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          zero_flag;
    logic          overflow;
    logic [IW-1:0] instruction;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          issue_valid;
    logic          busy;
    logic          done;
    logic          ovf_err;
    logic [AW-1:0] pc;

    int n_pass  = 0;
    int n_total = 0;

    logic [EW-1:0] prog [DEPTH];
    int            exp_pcs[$];
    bit            exp_abort;

    always #5 clk = ~clk;

    // Stand-in ALU: add; zero on the 8-bit result; overflow on carry for 0xF-class opcodes.
    logic [DW:0] alu_sum;
    assign alu_sum   = {1'b0, data0} + {1'b0, data1};
    assign zero_flag = (alu_sum[DW-1:0] == '0);
    assign overflow  = (instruction[IW-1 -: 4] == 4'hF) && alu_sum[DW];

    alu_issue_sequencer #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .IW    (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .hold        (hold),
        .zero_flag   (zero_flag),
        .overflow    (overflow),
        .instruction (instruction),
        .data0       (data0),
        .data1       (data1),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done),
        .ovf_err     (ovf_err),
        .pc          (pc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, want);
    endtask

    function automatic logic [EW-1:0] mk(input bit l, input bit s, input logic [15:0] i,
                                         input logic [7:0] a, input logic [7:0] b);
        return {l, s, i, a, b};
    endfunction

    // Expected issue order for the current program, straight from the skip/end/abort rules.
    task automatic build_expect();
        int            p;
        logic [EW-1:0] e;
        logic [8:0]    s;
        exp_pcs.delete();
        exp_abort = 1'b0;
        p = 0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_pcs.push_back(p);
            e = prog[p];
            s = {1'b0, e[15:8]} + {1'b0, e[7:0]};
            if (e[31:28] == 4'hF && s[8]) begin
                exp_abort = 1'b1;
                break;
            end
            if (e[33] || p == DEPTH - 1) break;
            if (e[32] && s[7:0] == 8'h00) begin
                if (p + 2 > DEPTH - 1) break;
                p += 2;
            end else begin
                p += 1;
            end
        end
    endtask

    task automatic write(input int addr, input logic [EW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = d;
        prog[addr] = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic check_idle(input string tag, input bit want_done, input bit want_ovf);
        check({tag, ".word"}, {instruction, data0, data1}, 64'h0);
        check({tag, ".valid"}, issue_valid, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".pc"}, pc, 0);
        check({tag, ".done"}, done, want_done);
        check({tag, ".ovf"}, ovf_err, want_ovf);
    endtask

    task automatic check_word(input string tag, input int p);
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".valid"}, issue_valid, 1'b1);
        check({tag, ".pc"}, pc, p);
        check({tag, ".word"}, {instruction, data0, data1}, prog[p][31:0]);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".ovf"}, ovf_err, 1'b0);
    endtask

    // One full run; writes attempted during ISSUE must not reach the program.
    task automatic run(input string tag, input bit wr0, input logic [EW-1:0] wr0_data,
                       input int hold_pc, input int hold_n, input bit rand_hold,
                       input bit rand_we);
        int nh;
        start = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr0_data;
            prog[0]   = wr0_data;
        end
        build_expect();
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        foreach (exp_pcs[i]) begin
            check_word(tag, exp_pcs[i]);
            if (exp_pcs[i] == hold_pc) nh = hold_n;
            else if (rand_hold && $urandom_range(0, 3) == 0) nh = $urandom_range(1, 3);
            else nh = 0;
            for (int k = 0; k < nh; k++) begin
                hold      = 1'b1;
                prog_we   = rand_we;
                prog_addr = AW'($urandom);
                prog_data = EW'({$urandom, $urandom});
                @(posedge clk); #1;
                check_word({tag, ".hold"}, exp_pcs[i]);
            end
            hold      = 1'b0;
            prog_we   = rand_we && ($urandom_range(0, 1) == 1);
            prog_addr = AW'($urandom);
            prog_data = EW'({$urandom, $urandom});
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        check_idle({tag, ".end"}, !exp_abort, exp_abort);
        @(posedge clk); #1;
        check_idle({tag, ".after"}, 1'b0, exp_abort);
    endtask

    function automatic logic [EW-1:0] rand_entry();
        logic [7:0]  a, b;
        logic [15:0] ins;
        a   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        b   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        ins = 16'($urandom);
        return mk($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, ins, a, b);
    endfunction

    initial begin
        #12;
        check_idle("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) write(i, mk(1'b0, 1'b0, 16'h0A00 + 16'(i), 8'(i), 8'h01));

        // Straight three-entry program.
        write(0, mk(1'b0, 1'b0, 16'h1234, 8'd3, 8'd4));
        write(1, mk(1'b0, 1'b0, 16'h2000, 8'd5, 8'd6));
        write(2, mk(1'b1, 1'b0, 16'h3000, 8'd7, 8'd8));
        run("straight", 1'b0, '0, -1, 0, 1'b0, 1'b0);
        check("straight.len", exp_pcs.size(), 3);

        // Skip taken, then not taken.
        write(0, mk(1'b0, 1'b1, 16'h0100, 8'd0, 8'd0));
        run("skip_z1", 1'b0, '0, -1, 0, 1'b0, 1'b0);
        write(0, mk(1'b0, 1'b1, 16'h0100, 8'd1, 8'd0));
        run("skip_z0", 1'b0, '0, -1, 0, 1'b0, 1'b0);

        // Overflow abort, then a restart clears ovf_err.
        write(1, mk(1'b0, 1'b0, 16'hFFFF, 8'd255, 8'd255));
        run("ovf", 1'b0, '0, -1, 0, 1'b0, 1'b0);
        run("ovf_again", 1'b0, '0, -1, 0, 1'b0, 1'b0);

        // Hold three cycles at pc 1.
        write(1, mk(1'b0, 1'b1, 16'h2000, 8'd0, 8'd0));
        write(2, mk(1'b1, 1'b0, 16'h3000, 8'd7, 8'd8));
        run("hold", 1'b0, '0, 1, 3, 1'b0, 1'b1);

        // start together with a write to entry 0.
        run("start_we", 1'b1, mk(1'b0, 1'b0, 16'h4444, 8'd9, 8'd9), -1, 0, 1'b0, 1'b0);

        // Full 16-entry program, none last.
        for (int i = 0; i < DEPTH; i++) write(i, mk(1'b0, 1'b0, 16'h0500 + 16'(i), 8'(i), 8'h02));
        run("full", 1'b0, '0, -1, 0, 1'b1, 1'b1);
        check("full.len", exp_pcs.size(), DEPTH);

        // Reset mid-run, then the retained program reissues from entry 0.
        start = 1'b1;
        build_expect();
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_word("rst_mid", exp_pcs[i]);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        check_idle("rst_async", 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("rst_rerun", 1'b0, '0, -1, 0, 1'b0, 1'b0);

        // Random programs with random hold and ignored writes during issue.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) write(i, rand_entry());
            run("rand", $urandom_range(0, 3) == 0, rand_entry(), -1, 0, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
